// File: rtl/deadtime_gen_nch.sv
// Multi-channel dead-time generator for half-bridge gate drive.
// Two-flop input pipeline, per-leg PASS/DEAD FSM, sticky shoot-through flags.
module deadtime_gen_nch #(
  parameter int NUM_CH = 3,
  parameter int DT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DT_W-1:0]   dt_cycles,
  input  logic [NUM_CH-1:0] high_in,
  input  logic [NUM_CH-1:0] low_in,
  output logic [NUM_CH-1:0] high_out,
  output logic [NUM_CH-1:0] low_out,
  output logic [NUM_CH-1:0] dt_busy,
  output logic [NUM_CH-1:0] fault,
  input  logic              fault_clr
);

  typedef enum logic {PASS, DEAD} state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [DT_W-1:0]   cnt_q   [NUM_CH];
  logic [DT_W-1:0]   cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] hi_q, hi_qq;
  logic [NUM_CH-1:0] lo_q, lo_qq;
  logic [NUM_CH-1:0] hout_q, hout_d;
  logic [NUM_CH-1:0] lout_q, lout_d;
  logic [NUM_CH-1:0] fault_q, fault_d;
  logic [NUM_CH-1:0] chg, shoot;
  logic [NUM_CH-1:0] busy;

  always_comb begin
    chg   = (hi_q ^ hi_qq) | (lo_q ^ lo_qq);
    shoot = hi_q & lo_q;
    // a fresh overlap beats a coincident clear
    fault_d = fault_clr ? shoot : (fault_q | shoot);
  end

  always_comb begin
    hout_d = '0;
    lout_d = '0;
    busy   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      busy[ch]    = (state_q[ch] == DEAD);
      if (!en) begin
        state_d[ch] = PASS;
        cnt_d[ch]   = '0;
      end else begin
        unique case (state_q[ch])
          PASS: begin
            if (chg[ch] && (dt_cycles != '0)) begin
              state_d[ch] = DEAD;
              cnt_d[ch]   = dt_cycles - DT_W'(1);
            end else begin
              cnt_d[ch]  = '0;
              hout_d[ch] = hi_q[ch];
              lout_d[ch] = lo_q[ch];
            end
          end
          DEAD: begin
            if (chg[ch]) begin
              if (dt_cycles != '0) begin
                cnt_d[ch] = dt_cycles - DT_W'(1);
              end else begin
                state_d[ch] = PASS;
                cnt_d[ch]   = '0;
              end
            end else if (cnt_q[ch] != '0) begin
              cnt_d[ch] = cnt_q[ch] - DT_W'(1);
            end else begin
              state_d[ch] = PASS;
              hout_d[ch]  = hi_q[ch];
              lout_d[ch]  = lo_q[ch];
            end
          end
        endcase
      end
      if (shoot[ch]) begin
        hout_d[ch] = 1'b0;
        lout_d[ch] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= '0;
      hi_qq   <= '0;
      lo_q    <= '0;
      lo_qq   <= '0;
      hout_q  <= '0;
      lout_q  <= '0;
      fault_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= PASS;
        cnt_q[ch]   <= '0;
      end
    end else begin
      hi_q    <= high_in;
      hi_qq   <= hi_q;
      lo_q    <= low_in;
      lo_qq   <= lo_q;
      hout_q  <= hout_d;
      lout_q  <= lout_d;
      fault_q <= fault_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  assign high_out = hout_q;
  assign low_out  = lout_q;
  assign dt_busy  = busy;
  assign fault    = fault_q;

endmodule

// File: tb/tb_deadtime_gen_nch.sv
// Bench for deadtime_gen_nch: directed table, corner sequences,
// and random stimulus against a remaining-dead-time reference model.
module tb_deadtime_gen_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fault_clr = 1'b0;
  logic [5:0] dt3 = '0;
  logic [3:0] dt6 = '0;
  logic [2:0] hi3 = '0, lo3 = '0;
  logic [2:0] ho3, lo3o, bz3, ft3;
  logic [5:0] hi6 = '0, lo6 = '0;
  logic [5:0] ho6, lo6o, bz6, ft6;

  int checks = 0;
  int failures = 0;

  deadtime_gen_nch u3 (
    .clk(clk), .rst(rst), .en(en), .dt_cycles(dt3),
    .high_in(hi3), .low_in(lo3), .high_out(ho3), .low_out(lo3o),
    .dt_busy(bz3), .fault(ft3), .fault_clr(fault_clr)
  );

  deadtime_gen_nch #(.NUM_CH(6), .DT_W(4)) u6 (
    .clk(clk), .rst(rst), .en(en), .dt_cycles(dt6),
    .high_in(hi6), .low_in(lo6), .high_out(ho6), .low_out(lo6o),
    .dt_busy(bz6), .fault(ft6), .fault_clr(fault_clr)
  );

  // Reference model: per leg, remaining dead cycles plus delayed inputs.
  bit mhq [2][6], mhqq [2][6], mlq [2][6], mlqq [2][6];
  bit mho [2][6], mlo [2][6], mf [2][6];
  int mleft [2][6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 6; c++) begin
        mhq[d][c] = 0; mhqq[d][c] = 0; mlq[d][c] = 0; mlqq[d][c] = 0;
        mho[d][c] = 0; mlo[d][c] = 0; mf[d][c] = 0; mleft[d][c] = 0;
      end
  endtask

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      int n;
      int dt;
      n  = (d == 0) ? 3 : 6;
      dt = (d == 0) ? int'(dt3) : int'(dt6);
      for (int c = 0; c < n; c++) begin
        bit hin, lin, chg, st, oh, ol;
        if (d == 0) begin hin = hi3[c]; lin = lo3[c]; end
        else begin hin = hi6[c]; lin = lo6[c]; end
        chg = (mhq[d][c] != mhqq[d][c]) || (mlq[d][c] != mlqq[d][c]);
        st  = mhq[d][c] && mlq[d][c];
        oh = 0; ol = 0;
        if (!en) begin
          mleft[d][c] = 0;
        end else if (chg) begin
          if (mleft[d][c] == 0 && dt == 0) begin
            oh = mhq[d][c]; ol = mlq[d][c];
          end
          mleft[d][c] = dt;
        end else if (mleft[d][c] > 0) begin
          mleft[d][c]--;
          if (mleft[d][c] == 0) begin oh = mhq[d][c]; ol = mlq[d][c]; end
        end else begin
          oh = mhq[d][c]; ol = mlq[d][c];
        end
        if (st) begin oh = 0; ol = 0; end
        mho[d][c] = oh;
        mlo[d][c] = ol;
        mf[d][c]  = fault_clr ? st : (mf[d][c] | st);
        mhqq[d][c] = mhq[d][c]; mhq[d][c] = hin;
        mlqq[d][c] = mlq[d][c]; mlq[d][c] = lin;
      end
    end
  endtask

  task automatic cmp_model();
    logic [5:0] eh, el, eb, ef;
    for (int d = 0; d < 2; d++) begin
      eh = '0; el = '0; eb = '0; ef = '0;
      for (int c = 0; c < 6; c++) begin
        eh[c] = mho[d][c]; el[c] = mlo[d][c];
        eb[c] = (mleft[d][c] > 0); ef[c] = mf[d][c];
      end
      if (d == 0) begin
        chk("m3_high", {29'd0, ho3}, {26'd0, eh});
        chk("m3_low", {29'd0, lo3o}, {26'd0, el});
        chk("m3_busy", {29'd0, bz3}, {26'd0, eb});
        chk("m3_fault", {29'd0, ft3}, {26'd0, ef});
      end else begin
        chk("m6_high", {26'd0, ho6}, {26'd0, eh});
        chk("m6_low", {26'd0, lo6o}, {26'd0, el});
        chk("m6_busy", {26'd0, bz6}, {26'd0, eb});
        chk("m6_fault", {26'd0, ft6}, {26'd0, ef});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m_reset(); else m_edge();
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic hi, lo;
    int   dt;
    logic eh, el, eb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int lows, done, bad;

    // dt=4, then dt=1, then dt=0 on channel 1 (steady at hi=1 before)
    tbl.push_back('{1, 0, 4, 1, 0, 0});
    tbl.push_back('{0, 1, 4, 1, 0, 0});
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 1, 4, 0, 0, 1});
    tbl.push_back('{0, 1, 4, 0, 1, 0});
    tbl.push_back('{0, 1, 4, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 0});

    m_reset();
    // reset with random inputs
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hi3 = 3'($urandom); lo3 = 3'($urandom);
      hi6 = 6'($urandom); lo6 = 6'($urandom);
      step();
      chk("rst_out", {ho3, lo3o, bz3, ft3}, 0);
      chk("rst_out6", {ho6, lo6o, bz6, ft6}, 0);
    end
    hi3 = '0; lo3 = '0; hi6 = '0; lo6 = '0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    hi3[0] = 1'b1;
    step();
    chk("idle_edge1", {31'd0, ho3[0]}, 0);
    step();
    chk("idle_edge2", {31'd0, ho3[0]}, 1);

    // directed table on channel 1
    dt3 = 6'd4;
    hi3[1] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    foreach (tbl[i]) begin
      hi3[1] = tbl[i].hi;
      lo3[1] = tbl[i].lo;
      dt3 = 6'(tbl[i].dt);
      step();
      chk($sformatf("tbl%0d", i), {29'd0, ho3[1], lo3o[1], bz3[1]},
          {29'd0, tbl[i].eh, tbl[i].el, tbl[i].eb});
    end

    // maximum dead time
    dt3 = 6'd63;
    hi3[1] = 1'b1; lo3[1] = 1'b0;
    step();
    chk("dt63_old", {30'd0, ho3[1], lo3o[1]}, 1);
    bad = 0;
    for (int j = 0; j < 63; j++) begin
      step();
      if (ho3[1] || lo3o[1] || !bz3[1]) bad++;
    end
    chk("dt63_dead", bad, 0);
    step();
    chk("dt63_new", {30'd0, ho3[1], bz3[1]}, 2);

    // retrigger on channel 2
    dt3 = 6'd8;
    hi3[2] = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("retrig_pre", {31'd0, ho3[2]}, 1);
    hi3[2] = 1'b0;
    step();
    lows = 0; done = 0;
    for (int i = 0; i < 40 && done == 0; i++) begin
      if (i == 2) hi3[2] = 1'b1;
      step();
      if (ho3[2]) done = 1; else lows++;
    end
    chk("retrig_done", done, 1);
    chk("retrig_low", lows, 11);

    // shoot-through on channel 0
    dt3 = 6'd2;
    lo3[0] = 1'b1;
    step();
    chk("st_nofault", {31'd0, ft3[0]}, 0);
    step();
    chk("st_fault", {31'd0, ft3[0]}, 1);
    chk("st_outs", {30'd0, ho3[0], lo3o[0]}, 0);
    hi3[0] = 1'b0; lo3[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("st_sticky", {31'd0, ft3[0]}, 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("st_clr", {31'd0, ft3[0]}, 0);
    hi3[0] = 1'b1; lo3[0] = 1'b1;
    step();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("st_setwins", {31'd0, ft3[0]}, 1);
    hi3[0] = 1'b0; lo3[0] = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // enable drop while all legs are dead
    dt3 = 6'd20;
    lo3 = '0;
    hi3 = 3'b101;
    for (int i = 0; i < 25; i++) step();
    hi3 = ~hi3;
    step();
    step();
    chk("en_busy", {29'd0, bz3}, 7);
    en = 1'b0;
    step();
    chk("en_off", {ho3, lo3o, bz3}, 0);
    chk("en_fault", {31'd0, ft3[0]}, 1);
    en = 1'b1;
    step();
    chk("en_resume", {29'd0, ho3}, 3'b010);

    // asynchronous reset between edges
    dt3 = '0;
    hi3 = 3'b111;
    for (int i = 0; i < 3; i++) step();
    chk("ar_pre", {29'd0, ho3}, 7);
    #3 rst = 1'b1;
    #1;
    chk("ar_drop", {ho3, lo3o, bz3, ft3}, 0);
    m_reset();
    step();
    rst = 1'b0;
    hi3 = '0;
    step();

    // staggered toggles on the six-leg instance
    dt6 = 4'd5;
    for (int c = 0; c < 6; c++) begin
      hi6[c] = 1'b1;
      step();
    end
    for (int i = 0; i < 10; i++) step();
    chk("ind6_high", {26'd0, ho6}, 6'h3f);

    // random stimulus against the model
    for (int n = 0; n < 800; n++) begin
      en = ($urandom_range(0, 24) != 0);
      fault_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0)
        dt3 = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) dt6 = 4'($urandom_range(0, 15));
      for (int c = 0; c < 6; c++) begin
        int r;
        r = $urandom_range(0, 11);
        if (c < 3) begin
          if (r == 0) hi3[c] = ~hi3[c];
          else if (r == 1) lo3[c] = ~lo3[c];
          else if (r == 2) begin hi3[c] = lo3[c]; lo3[c] = ~lo3[c]; end
        end
        r = $urandom_range(0, 11);
        if (r == 0) hi6[c] = ~hi6[c];
        else if (r == 1) lo6[c] = ~lo6[c];
        else if (r == 2) begin hi6[c] = lo6[c]; lo6[c] = ~lo6[c]; end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
